// File: rtl/demorgan_pkg.sv
// Shared types, output bit map and golden truth function for the De Morgan sweep checker.
package demorgan_pkg;

    localparam int unsigned NOUT = 6;

    localparam int unsigned IdxNA      = 0;
    localparam int unsigned IdxNB      = 1;
    localparam int unsigned IdxNAandNB = 2;
    localparam int unsigned IdxNotAorB = 3;
    localparam int unsigned IdxNotAxB  = 4;
    localparam int unsigned IdxNAorNB  = 5;

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    function automatic logic [NOUT-1:0] golden_vec(input logic a, input logic b);
        logic [NOUT-1:0] v;
        v             = '0;
        v[IdxNA]      = ~a;
        v[IdxNB]      = ~b;
        v[IdxNAandNB] = ~a & ~b;
        v[IdxNotAorB] = ~(a | b);
        v[IdxNotAxB]  = ~(a & b);
        v[IdxNAorNB]  = ~a | ~b;
        return v;
    endfunction

endpackage

// File: rtl/demorgan_golden.sv
// Combinational reference: expected gate outputs for an (a,b) input pair.
module demorgan_golden
    import demorgan_pkg::*;
(
    input  logic            a_i,
    input  logic            b_i,
    output logic [NOUT-1:0] exp_o
);

    assign exp_o = golden_vec(a_i, b_i);

endmodule

// File: rtl/demorgan_sweeper.sv
// Sweeps (a,b) through 00..11, waits Settle cycles per row, and checks the gate outputs
// against the golden model, reporting per-row mismatches and an overall pass flag.
module demorgan_sweeper
    import demorgan_pkg::*;
#(
    parameter int unsigned Settle = 1,
    parameter int unsigned Nout   = NOUT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            a_o,
    output logic            b_o,
    input  logic [Nout-1:0] dut_out_i,
    output logic            busy_o,
    output logic            row_valid_o,
    output logic [1:0]      row_index_o,
    output logic [Nout-1:0] row_mismatch_o,
    output logic [2:0]      err_count_o,
    output logic            done_o,
    output logic            pass_o
);

    localparam logic [3:0] SettleLast = 4'(Settle - 1);

    state_e            state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        err_q, err_d;
    logic [1:0]        ab_q, ab_d;
    logic              busy_q, busy_d;
    logic              rv_q, rv_d;
    logic [1:0]        ridx_q, ridx_d;
    logic [Nout-1:0]   mm_q, mm_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [Nout-1:0]   expected;
    logic [Nout-1:0]   mismatch;

    demorgan_golden u_golden (
        .a_i   (row_q[1]),
        .b_i   (row_q[0]),
        .exp_o (expected)
    );

    assign mismatch = dut_out_i ^ expected;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = StSettle;
            StSettle: if (cnt_q == SettleLast) state_d = StCheck;
            StCheck:  state_d = (row_q == 2'd3) ? StDone : StSettle;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        row_d  = row_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        ab_d   = ab_q;
        busy_d = busy_q;
        rv_d   = 1'b0;
        ridx_d = ridx_q;
        mm_d   = mm_q;
        done_d = 1'b0;
        pass_d = pass_q;
        unique case (state_q)
            StIdle: begin
                ab_d   = 2'b00;
                busy_d = start_i;
                if (start_i) begin
                    row_d  = 2'd0;
                    cnt_d  = 4'd0;
                    err_d  = 3'd0;
                    pass_d = 1'b0;
                end
            end
            StSettle: begin
                ab_d   = row_q;
                busy_d = 1'b1;
                cnt_d  = cnt_q + 4'd1;
            end
            StCheck: begin
                busy_d = 1'b1;
                rv_d   = 1'b1;
                ridx_d = row_q;
                mm_d   = mismatch;
                // Clean row in the then-branch so an unknown compare lands on the error path.
                if (mismatch == '0) begin
                    err_d = err_q;
                end else begin
                    err_d = err_q + 3'd1;
                end
                if (row_q == 2'd3) begin
                    pass_d = (err_d == 3'd0);
                end else begin
                    row_d = row_q + 2'd1;
                    cnt_d = 4'd0;
                    ab_d  = row_q + 2'd1;
                end
            end
            StDone: begin
                busy_d = 1'b1;
                done_d = 1'b1;
                ab_d   = 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q  <= 2'd0;
            cnt_q  <= 4'd0;
            err_q  <= 3'd0;
            ab_q   <= 2'b00;
            busy_q <= 1'b0;
            rv_q   <= 1'b0;
            ridx_q <= 2'd0;
            mm_q   <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            ab_q   <= ab_d;
            busy_q <= busy_d;
            rv_q   <= rv_d;
            ridx_q <= ridx_d;
            mm_q   <= mm_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign a_o            = ab_q[1];
    assign b_o            = ab_q[0];
    assign busy_o         = busy_q;
    assign row_valid_o    = rv_q;
    assign row_index_o    = ridx_q;
    assign row_mismatch_o = mm_q;
    assign err_count_o    = err_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;

endmodule

// File: tb/tb_demorgan_sweeper.sv
// Directed bench: a Settle=1 sweeper fed by a switchable gate model, and a Settle=3 sweeper
// fed by a two-cycle-delayed gate model.
module tb_demorgan_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    int   mode = 0;

    always #5 clk = ~clk;

    logic       a1, b1, busy1, rv1, done1, pass1;
    logic [1:0] ri1;
    logic [5:0] mm1, dout1;
    logic [2:0] ec1;
    logic       a3, b3, busy3, rv3, done3, pass3;
    logic [1:0] ri3;
    logic [5:0] mm3, dout3;
    logic [2:0] ec3;

    logic [5:0] d1a = 6'h3f, d1b = 6'h3f, d3a = 6'h3f, d3b = 6'h3f;

    int checks = 0;
    int fails  = 0;

    demorgan_sweeper #(.Settle(1)) u_dut1 (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start1),
        .a_o            (a1),
        .b_o            (b1),
        .dut_out_i      (dout1),
        .busy_o         (busy1),
        .row_valid_o    (rv1),
        .row_index_o    (ri1),
        .row_mismatch_o (mm1),
        .err_count_o    (ec1),
        .done_o         (done1),
        .pass_o         (pass1)
    );

    demorgan_sweeper #(.Settle(3)) u_dut3 (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start3),
        .a_o            (a3),
        .b_o            (b3),
        .dut_out_i      (dout3),
        .busy_o         (busy3),
        .row_valid_o    (rv3),
        .row_index_o    (ri3),
        .row_mismatch_o (mm3),
        .err_count_o    (ec3),
        .done_o         (done3),
        .pass_o         (pass3)
    );

    // Stand-in for the wired-up gate modules.
    function automatic logic [5:0] gates(input logic a, input logic b);
        logic [5:0] v;
        v[0] = !a;
        v[1] = !b;
        v[2] = !a && !b;
        v[3] = !(a || b);
        v[4] = !(a && b);
        v[5] = !a || !b;
        return v;
    endfunction

    always @(posedge clk) begin
        d1a <= gates(a1, b1);
        d1b <= d1a;
        d3a <= gates(a3, b3);
        d3b <= d3a;
    end

    always_comb begin
        dout1 = gates(a1, b1);
        case (mode)
            1: dout1[4] = 1'b0;
            2: if ({a1, b1} == 2'b01) dout1 = 6'bxxxxxx;
            3: dout1 = d1b;
            default: ;
        endcase
    end

    assign dout3 = d3b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input logic cond);
        checks++;
        if (cond !== 1'b1) begin
            fails++;
            $display("FAIL %s: condition not met", name);
        end
    endtask

    typedef struct {
        string      tag;
        int         sel;
        int         mode;
        logic [23:0] mm;   // {row3,row2,row1,row0}
        logic [3:0] any;   // row expected merely nonzero
        logic [2:0] err;
        logic       pass;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int s, nrow, ndone, last;
        logic rv, dn, bz, ps;
        logic [1:0] ri;
        logic [5:0] mm;
        logic [2:0] ec;
        s     = (v.sel == 1) ? 3 : 1;
        last  = 4 * (s + 1) + 1;
        nrow  = 0;
        ndone = 0;
        mode  = v.mode;
        repeat (4) @(negedge clk);
        if (v.sel == 1) start3 = 1'b1; else start1 = 1'b1;
        for (int c = 0; c <= last + 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            start3 = 1'b0;
            if (v.sel == 1) begin
                rv = rv3; dn = done3; bz = busy3; ps = pass3; ri = ri3; mm = mm3; ec = ec3;
            end else begin
                rv = rv1; dn = done1; bz = busy1; ps = pass1; ri = ri1; mm = mm1; ec = ec1;
            end
            if (rv === 1'b1 && nrow < 4) begin
                check({v.tag, " row_valid timing"}, c, (nrow + 1) * (s + 1));
                check({v.tag, " row_index"}, ri, nrow);
                if (v.any[nrow]) check_true({v.tag, " row_mismatch nonzero"}, mm !== 6'b0);
                else check({v.tag, " row_mismatch"}, mm, v.mm[6*nrow +: 6]);
                nrow++;
            end
            if (dn === 1'b1) begin
                ndone++;
                check({v.tag, " done timing"}, c, last);
                check({v.tag, " pass"}, ps, v.pass);
                check({v.tag, " err_count"}, ec, v.err);
            end
            if (c == last) check({v.tag, " busy through done"}, bz, 1);
            if (c == last + 1) check({v.tag, " busy falls"}, bz, 0);
        end
        check({v.tag, " row count"}, nrow, 4);
        check({v.tag, " done count"}, ndone, 1);
    endtask

    initial begin
        int ndone, nrv;

        vecs[0] = '{"golden", 0, 0, 24'h0, 4'b0000, 3'd0, 1'b1};
        vecs[1] = '{"stuck4", 0, 1, {6'b000000, 6'b010000, 6'b010000, 6'b010000},
                    4'b0000, 3'd3, 1'b0};
        vecs[2] = '{"xrow1", 0, 2, 24'h0, 4'b0010, 3'd1, 1'b0};
        vecs[3] = '{"delay_s1", 0, 3, {6'b110010, 6'b000011, 6'b001110, 6'b000000},
                    4'b0000, 3'd3, 1'b0};
        vecs[4] = '{"delay_s3", 1, 0, 24'h0, 4'b0000, 3'd0, 1'b1};

        #3;
        check("reset outputs dut1", {a1, b1, busy1, rv1, ri1, mm1, ec1, done1, pass1}, 0);
        check("reset outputs dut3", {a3, b3, busy3, rv3, ri3, mm3, ec3, done3, pass3}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Asynchronous reset during row 2 settle.
        mode = 0;
        repeat (4) @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
        end
        check("pre-reset row2 inputs", {a1, b1}, 2'b10);
        check("pre-reset row_valid", rv1, 1);
        #2 rst = 1'b1;
        #1;
        check("reset abort outputs", {a1, b1, busy1, rv1, ri1, mm1, ec1, done1, pass1}, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done1 === 1'b1) ndone++;
        end
        check("no done after abort", ndone, 0);
        check("idle after abort busy", busy1, 0);
        run_vec(vecs[0]);

        // Start pulses during SETTLE and DONE are ignored.
        repeat (4) @(negedge clk);
        start1 = 1'b1;
        ndone = 0;
        for (int c = 0; c <= 24; c++) begin
            @(posedge clk);
            @(negedge clk);
            start1 = (c == 2) || (c == 8);
            if (done1 === 1'b1) begin
                ndone++;
                check("ignored-start done timing", c, 9);
                check("ignored-start pass", pass1, 1);
            end
            if (c == 10) check("ignored-start busy falls", busy1, 0);
        end
        check("ignored-start done count", ndone, 1);

        // Start held high: back-to-back sweeps one IDLE cycle apart.
        repeat (4) @(negedge clk);
        start1 = 1'b1;
        ndone = 0;
        nrv = 0;
        for (int c = 0; c <= 24; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 18) start1 = 1'b0;
            if (rv1 === 1'b1) nrv++;
            if (done1 === 1'b1) begin
                ndone++;
                check("held-start done timing", c, (ndone == 1) ? 9 : 19);
            end
            if (c == 10) check("held-start busy stays", busy1, 1);
            if (c == 12) check("held-start second sweep row0", {rv1, ri1}, 3'b100);
            if (c == 21) check("held-start busy falls", busy1, 0);
        end
        check("held-start done count", ndone, 2);
        check("held-start row_valid count", nrv, 8);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
